// File: rtl/io_deq_policy_pkg.sv
// Shared types and sizing for the issue-queue dequeue pointer policy.
package io_deq_policy_pkg;

   localparam int unsigned ISSUE_QUEUE_DEPTH = 8;
   localparam int unsigned IO_DEQ_CNT_W      = 32;

   typedef enum logic [1:0] {
      IO_DEQ_EMPTY   = 2'd0,
      IO_DEQ_ISSUE   = 2'd1,
      IO_DEQ_RECOVER = 2'd2
   } io_deq_state_e;

endpackage

// File: rtl/io_deq_policy_find_first1_base.sv
// Circular first-set search: returns the lowest set bit of req at or above the
// one-hot base position, wrapping past the top. Zero when req is zero.
module io_deq_policy_find_first1_base #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] base,
   output logic [WIDTH-1:0] grant
);

   logic [2*WIDTH-1:0] dbl_req;
   logic [2*WIDTH-1:0] dbl_gnt;

   // Subtracting base from the doubled vector clears everything below base and
   // flips the first set bit at or above it; masking isolates that bit.
   assign dbl_req = {req, req};
   assign dbl_gnt = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
   assign grant   = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/io_deq_policy.sv
// Dequeue-side head pointer policy for the in-order issue queue.
// Optional head-stall counter enabled by defining IO_DEQ_PERF_EN.
module io_deq_policy
   import io_deq_policy_pkg::*;
#(
   parameter int unsigned DEPTH = ISSUE_QUEUE_DEPTH,
   parameter int unsigned CNT_W = IO_DEQ_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic [DEPTH-1:0] valid_dec,
   input  logic [DEPTH-1:0] rdy_dec,
   input  logic [DEPTH-1:0] enq_ptr_oh,
   input  logic             enq_fire,
   input  logic             deq_ready,
   output logic             deq_valid,
   output logic             deq_fire,
   output logic [DEPTH-1:0] deq_ptr_oh,
   output logic [DEPTH-1:0] deq_clear_oh,
   output logic             deq_empty,
   output logic [CNT_W-1:0] perf_head_stall_cnt
);

   io_deq_state_e    state_q;
   io_deq_state_e    state_d;
   logic [DEPTH-1:0] ptr_q;
   logic [DEPTH-1:0] ptr_d;
   logic [DEPTH-1:0] survivor_oh;
   logic [DEPTH-1:0] realign_oh;
   logic             head_ok;
   logic             others_valid;

   io_deq_policy_find_first1_base #(
      .WIDTH (DEPTH)
   ) u_realign (
      .req   (valid_dec),
      .base  (enq_ptr_oh),
      .grant (survivor_oh)
   );

   // Searching from the enqueue pointer finds the oldest surviving entry.
   assign realign_oh   = (|valid_dec) ? survivor_oh : enq_ptr_oh;
   assign others_valid = |(valid_dec & ~ptr_q);
   assign head_ok      = |(ptr_q & valid_dec & rdy_dec);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IO_DEQ_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IO_DEQ_RECOVER;
      end else begin
         unique case (state_q)
            IO_DEQ_RECOVER: state_d = (|valid_dec) ? IO_DEQ_ISSUE : IO_DEQ_EMPTY;
            IO_DEQ_EMPTY:   state_d = enq_fire ? IO_DEQ_ISSUE : IO_DEQ_EMPTY;
            IO_DEQ_ISSUE: begin
               if (deq_fire && !others_valid && !enq_fire) begin
                  state_d = IO_DEQ_EMPTY;
               end
            end
            default:        state_d = IO_DEQ_EMPTY;
         endcase
      end
   end

   always_comb begin
      deq_valid    = !reset && !flush && (state_q == IO_DEQ_ISSUE) && head_ok;
      deq_fire     = deq_valid && deq_ready;
      deq_clear_oh = deq_fire ? ptr_q : '0;
      deq_empty    = (state_q == IO_DEQ_EMPTY);
      deq_ptr_oh   = ptr_q;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (flush) begin
         ptr_d = ptr_q;
      end else if (state_q == IO_DEQ_RECOVER) begin
         ptr_d = realign_oh;
      end else if (state_q == IO_DEQ_EMPTY) begin
         ptr_d = enq_ptr_oh;
      end else if (deq_fire) begin
         ptr_d = {ptr_q[DEPTH-2:0], ptr_q[DEPTH-1]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= {{(DEPTH-1){1'b0}}, 1'b1};
      end else begin
         ptr_q <= ptr_d;
      end
   end

`ifdef IO_DEQ_PERF_EN
   logic             head_stall;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   assign head_stall = |(ptr_q & valid_dec & ~rdy_dec);

   // Saturating; deliberately survives flush so stalls accumulate across recoveries.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IO_DEQ_ISSUE) && (head_stall || (deq_valid && !deq_ready))
          && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_head_stall_cnt = stall_cnt_q;
`else
   assign perf_head_stall_cnt = '0;
`endif

   a_deq_ptr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot(deq_ptr_oh))
      else $error("deq_ptr_oh lost its one-hot property");

endmodule

// File: tb/tb_io_deq_policy.sv
// Bench for io_deq_policy: directed table, hand sequences and random stimulus
// against an index-based reference model. Honours IO_DEQ_PERF_EN.
module tb_io_deq_policy;

   localparam int unsigned D  = 8;
   localparam int unsigned CW = 8;

   logic          clock = 1'b0;
   logic          reset, flush, enq_fire, deq_ready;
   logic [D-1:0]  valid_dec, rdy_dec, enq_ptr_oh;
   logic          deq_valid, deq_fire, deq_empty;
   logic [D-1:0]  deq_ptr_oh, deq_clear_oh;
   logic [CW-1:0] perf_head_stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   io_deq_policy #(.DEPTH(D), .CNT_W(CW)) dut (
      .clock               (clock),
      .reset               (reset),
      .flush               (flush),
      .valid_dec           (valid_dec),
      .rdy_dec             (rdy_dec),
      .enq_ptr_oh          (enq_ptr_oh),
      .enq_fire            (enq_fire),
      .deq_ready           (deq_ready),
      .deq_valid           (deq_valid),
      .deq_fire            (deq_fire),
      .deq_ptr_oh          (deq_ptr_oh),
      .deq_clear_oh        (deq_clear_oh),
      .deq_empty           (deq_empty),
      .perf_head_stall_cnt (perf_head_stall_cnt)
   );

   // Reference model: mode 0=empty, 1=issuing, 2=recovering; head is an index.
   int            m_mode = 0;
   int unsigned   m_head = 0;
   logic [CW-1:0] m_cnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned idx_of(input logic [D-1:0] oh);
      for (int unsigned i = 0; i < D; i++) if (oh[i]) return i;
      return 0;
   endfunction

   function automatic logic m_valid();
      return !reset && !flush && (m_mode == 1) && valid_dec[m_head] && rdy_dec[m_head];
   endfunction

   task automatic model_compare();
      logic          mv;
      logic [D-1:0]  mptr;
      mv   = m_valid();
      mptr = D'(1) << m_head;
      chk("deq_valid", 32'(deq_valid), 32'(mv));
      chk("deq_fire", 32'(deq_fire), 32'(mv && deq_ready));
      chk("deq_clear_oh", 32'(deq_clear_oh), (mv && deq_ready) ? 32'(mptr) : 32'd0);
      chk("deq_ptr_oh", 32'(deq_ptr_oh), 32'(mptr));
      chk("deq_empty", 32'(deq_empty), 32'(m_mode == 0));
      chk("perf_cnt", 32'(perf_head_stall_cnt), 32'(m_cnt));
   endtask

   task automatic model_step();
      logic        fire, found;
      int unsigned e, nh, others;
      if (reset) begin
         m_mode = 0; m_head = 0; m_cnt = '0;
         return;
      end
      fire   = m_valid() && deq_ready;
      e      = idx_of(enq_ptr_oh);
      others = $countones(valid_dec) - 32'(valid_dec[m_head]);
`ifdef IO_DEQ_PERF_EN
      if (m_mode == 1 && ((valid_dec[m_head] && !rdy_dec[m_head]) || (m_valid() && !deq_ready))
          && m_cnt != '1)
         m_cnt = m_cnt + 1'b1;
`endif
      nh = m_head;
      if (flush) nh = m_head;
      else if (m_mode == 2) begin
         nh = e; found = 1'b0;
         for (int unsigned k = 0; k < D; k++)
            if (!found && valid_dec[(e + k) % D]) begin nh = (e + k) % D; found = 1'b1; end
      end else if (m_mode == 0) nh = e;
      else if (fire) nh = (m_head + 1) % D;
      if (flush) m_mode = 2;
      else if (m_mode == 2) m_mode = (valid_dec != 0) ? 1 : 0;
      else if (m_mode == 0) m_mode = enq_fire ? 1 : 0;
      else if (fire && others == 0 && !enq_fire) m_mode = 0;
      m_head = nh;
   endtask

   task automatic cycle_begin();
      @(negedge clock);
      model_compare();
   endtask

   task automatic cycle_end();
      @(posedge clock);
      model_step();
      #1;
   endtask

   typedef struct {
      logic rst, fl; logic [7:0] vld, rdy, enq; logic ef, dr;
      logic e_val; logic [7:0] e_clr, e_ptr; logic e_emp;
   } vec_t;
   vec_t tbl[$];

   task automatic row(input logic rst, fl, input logic [7:0] vld, rdy, enq, input logic ef, dr,
                      input logic ev, input logic [7:0] eclr, eptr, input logic eemp);
      vec_t v;
      v = '{rst, fl, vld, rdy, enq, ef, dr, ev, eclr, eptr, eemp};
      tbl.push_back(v);
   endtask

   initial begin
      //  rst   fl    vld    rdy    enq    ef    dr     val   clr    ptr    emp
      row(1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0,  1'b0, 8'h00, 8'h01, 1'b1);
      row(1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1,  1'b0, 8'h00, 8'h01, 1'b1);
      row(1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1,  1'b1, 8'h01, 8'h01, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1,  1'b0, 8'h00, 8'h02, 1'b1);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h80, 1'b1, 1'b0,  1'b0, 8'h00, 8'h02, 1'b1);
      row(1'b0, 1'b0, 8'h80, 8'h80, 8'h01, 1'b1, 1'b0,  1'b1, 8'h00, 8'h80, 1'b0);
      row(1'b0, 1'b0, 8'h81, 8'h81, 8'h02, 1'b0, 1'b1,  1'b1, 8'h80, 8'h80, 1'b0);
      row(1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1,  1'b1, 8'h01, 8'h01, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0,  1'b0, 8'h00, 8'h02, 1'b1);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0,  1'b0, 8'h00, 8'h02, 1'b1);
      row(1'b0, 1'b1, 8'h3C, 8'h3C, 8'h40, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b0, 8'h30, 8'h30, 8'h40, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b0, 8'h30, 8'h30, 8'h40, 1'b0, 1'b0,  1'b1, 8'h00, 8'h10, 1'b0);
      row(1'b0, 1'b1, 8'h30, 8'h30, 8'h40, 1'b0, 1'b0,  1'b0, 8'h00, 8'h10, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0,  1'b0, 8'h00, 8'h10, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0,  1'b0, 8'h00, 8'h08, 1'b1);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0,  1'b0, 8'h00, 8'h08, 1'b1);
      row(1'b0, 1'b0, 8'h02, 8'h02, 8'h04, 1'b1, 1'b1,  1'b1, 8'h02, 8'h02, 1'b0);
      row(1'b0, 1'b0, 8'h04, 8'h00, 8'h08, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b1, 8'h04, 8'h04, 8'h08, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b1, 8'h04, 8'h04, 8'h08, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b0, 8'h04, 8'h04, 8'h08, 1'b0, 1'b1,  1'b0, 8'h00, 8'h04, 1'b0);
      row(1'b0, 1'b0, 8'h04, 8'h04, 8'h08, 1'b0, 1'b1,  1'b1, 8'h04, 8'h04, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0,  1'b0, 8'h00, 8'h08, 1'b1);
      row(1'b1, 1'b0, 8'h08, 8'h08, 8'h10, 1'b0, 1'b1,  1'b0, 8'h00, 8'h08, 1'b0);
      row(1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0,  1'b0, 8'h00, 8'h01, 1'b1);

      reset = 1'b1; flush = 1'b0; valid_dec = '0; rdy_dec = '0;
      enq_ptr_oh = 8'h01; enq_fire = 1'b0; deq_ready = 1'b0;
      cycle_end();
      cycle_end();

      foreach (tbl[i]) begin
         reset = tbl[i].rst; flush = tbl[i].fl; valid_dec = tbl[i].vld; rdy_dec = tbl[i].rdy;
         enq_ptr_oh = tbl[i].enq; enq_fire = tbl[i].ef; deq_ready = tbl[i].dr;
         cycle_begin();
         chk($sformatf("tbl%0d_valid", i), 32'(deq_valid), 32'(tbl[i].e_val));
         chk($sformatf("tbl%0d_clear", i), 32'(deq_clear_oh), 32'(tbl[i].e_clr));
         chk($sformatf("tbl%0d_ptr", i), 32'(deq_ptr_oh), 32'(tbl[i].e_ptr));
         chk($sformatf("tbl%0d_empty", i), 32'(deq_empty), 32'(tbl[i].e_emp));
         cycle_end();
      end

      // Head entry 1 not ready while younger entry 2 is: nothing may issue.
      reset = 1'b1; flush = 1'b0; valid_dec = '0; rdy_dec = '0; enq_fire = 1'b0; deq_ready = 1'b1;
      cycle_begin(); cycle_end();
      reset = 1'b0; enq_ptr_oh = 8'h02; enq_fire = 1'b1;
      cycle_begin(); cycle_end();
      valid_dec = 8'h06; rdy_dec = 8'h04; enq_ptr_oh = 8'h08; enq_fire = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle_begin();
         chk("stall_valid", 32'(deq_valid), 32'd0);
         chk("stall_clear", 32'(deq_clear_oh), 32'd0);
         cycle_end();
      end
      cycle_begin();
`ifdef IO_DEQ_PERF_EN
      chk("stall_cnt5", 32'(perf_head_stall_cnt), 32'd5);
`else
      chk("stall_cnt5", 32'(perf_head_stall_cnt), 32'd0);
`endif
      chk("stall_ptr", 32'(deq_ptr_oh), 32'h02);
      cycle_end();
      for (int i = 0; i < 300; i++) begin cycle_begin(); cycle_end(); end
      cycle_begin();
`ifdef IO_DEQ_PERF_EN
      chk("stall_cnt_sat", 32'(perf_head_stall_cnt), 32'd255);
`else
      chk("stall_cnt_sat", 32'(perf_head_stall_cnt), 32'd0);
`endif
      cycle_end();

      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         valid_dec  = D'($urandom & $urandom & $urandom);
         rdy_dec    = D'($urandom | $urandom);
         enq_ptr_oh = D'(1) << $urandom_range(0, D - 1);
         enq_fire   = 1'($urandom_range(0, 1));
         deq_ready  = ($urandom_range(0, 3) != 0);
         cycle_begin();
         cycle_end();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
